// File: rtl/nrisc_pkg.sv
// Shared constants and state type for the nRisc narrow-datapath blocks.
package nrisc_pkg;

    localparam int unsigned NRISC_DATA_W  = 8;
    localparam int unsigned NRISC_CHUNK_W = 2;
    localparam int unsigned NRISC_NCHUNK  = NRISC_DATA_W / NRISC_CHUNK_W;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

    // Width of a counter indexing n items; a single item still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_len_calc.sv
// Number of chunks needed to carry a word: index of its highest nonzero chunk plus one,
// never less than one.
module chunk_len_calc
    import nrisc_pkg::*;
#(
    parameter  int unsigned DATA_W  = NRISC_DATA_W,
    parameter  int unsigned CHUNK_W = NRISC_CHUNK_W,
    localparam int unsigned NCHUNK  = DATA_W / CHUNK_W,
    localparam int unsigned LEN_W   = $clog2(NCHUNK + 1)
) (
    input  logic [DATA_W-1:0] word_i,
    output logic [LEN_W-1:0]  len_o
);

    always_comb begin
        len_o = LEN_W'(1);
        for (int unsigned i = 1; i < NCHUNK; i++) begin
            if (word_i[i*CHUNK_W +: CHUNK_W] != '0) begin
                len_o = LEN_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/narrow8to2_serializer.sv
// Splits a DATA_W word into CHUNK_W chunks over valid/ready streams.
// Define NARROW_SKIP_ZERO_EN to drop the all-zero high-order chunks of each word.
module narrow8to2_serializer
    import nrisc_pkg::*;
#(
    parameter int unsigned DATA_W    = NRISC_DATA_W,
    parameter int unsigned CHUNK_W   = NRISC_CHUNK_W,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [CHUNK_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy
);

    localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
    localparam int unsigned CNT_W  = cnt_width(NCHUNK);

    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  count_q, count_d;
    // Holds len-1 of the word in flight, so the exit compare never needs len itself.
    logic [CNT_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  accept_last;
    logic [CNT_W-1:0]  chunk_idx;
    logic              at_last;

`ifdef NARROW_SKIP_ZERO_EN
    localparam int unsigned LEN_W = $clog2(NCHUNK + 1);

    logic [LEN_W-1:0] word_len;

    chunk_len_calc #(
        .DATA_W  (DATA_W),
        .CHUNK_W (CHUNK_W)
    ) u_chunk_len_calc (
        .word_i (in_data),
        .len_o  (word_len)
    );

    assign accept_last = CNT_W'(word_len - LEN_W'(1));
`else
    assign accept_last = CNT_W'(NCHUNK - 1);
`endif

    assign at_last = (count_q == last_q);

    // MSB-first walks down from the highest chunk being sent, which also skips leading zeros.
    always_comb begin
        chunk_idx = MSB_FIRST ? (last_q - count_q) : count_q;
        out_data  = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (state_q == SEND && chunk_idx == CNT_W'(i)) begin
                out_data = word_q[i*CHUNK_W +: CHUNK_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        count_d = count_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    count_d = '0;
                    last_d  = accept_last;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SEND);
    assign out_valid = busy;
    assign out_last  = busy && at_last;

endmodule
